sampler_ctrl: RTL

Controller that sequences one vector-sampler run and owns the shared 64-bit data BRAM port while the run is active. On a start command it latches seed and destination base addresses, holds the sampler in reset for one launch cycle, and then releases it. While the sampler runs, its read and write addresses are translated onto the BRAM port. On completion it pulses `done` and hands the port back to the host/instruction decoder. It sits between the instruction decoder, the binomial vector sampler and the data BRAM.

---
 rtl/sampler_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sampler_ctrl.sv
// sampler_ctrl: sequences one vector-sampler run and owns the shared data BRAM
// port while the run is active.
//
// Ports:
//   clk, rst            - clock, async active-high reset
//   start, abort        - run command / cancel of an active run
//   seed_base, dst_base - BRAM word bases, latched on an accepted start
//   busy, done, aborted - run status (done is a 1-cycle pulse, aborted sticky)
//   run_cycles          - RUN cycles of the last run, saturating
//   smp_*               - binomial sampler handshake and address/data
//   host_*              - host/decoder access to the BRAM port
//   mem_*               - BRAM port (read data has 1-cycle latency)
module sampler_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] seed_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  run_cycles,
  output logic              smp_rst,
  input  logic [ADDR_W-1:0] smp_rd_address,
  input  logic [ADDR_W-1:0] smp_wt_address,
  input  logic              smp_wen,
  input  logic [DATA_W-1:0] smp_sample_pack,
  input  logic              smp_done,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic [DATA_W-1:0] smp_data_in
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_FINISH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] seed_q, seed_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  run_cycles_q, run_cycles_d;
  logic              aborted_q, aborted_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      seed_q       <= '0;
      dst_q        <= '0;
      run_cycles_q <= '0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      seed_q       <= seed_d;
      dst_q        <= dst_d;
      run_cycles_q <= run_cycles_d;
      aborted_q    <= aborted_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    seed_d       = seed_q;
    dst_d        = dst_q;
    run_cycles_d = run_cycles_q;
    aborted_d    = aborted_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          seed_d       = seed_base;
          dst_d        = dst_base;
          run_cycles_d = '0;
          aborted_d    = 1'b0;
          state_d      = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_RUN;
      S_RUN: begin
        // the abort cycle is still a RUN cycle, so it is counted too
        if (run_cycles_q != '1) run_cycles_d = run_cycles_q + 1'b1;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else if (smp_done) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // BRAM port ownership: host in IDLE, sampler otherwise
  always_comb begin
    host_gnt  = (state_q == S_IDLE) && host_req && !start;
    mem_addr  = host_addr;
    mem_we    = 1'b0;
    mem_wdata = host_wdata;
    if (state_q == S_IDLE) begin
      mem_we = host_gnt && host_we;
    end else begin
      // bases + offsets wrap modulo 2^ADDR_W
      mem_addr  = smp_wen ? (dst_q + smp_wt_address) : (seed_q + smp_rd_address);
      mem_we    = (state_q == S_RUN) && smp_wen;
      mem_wdata = smp_sample_pack;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FINISH);
  assign smp_rst     = (state_q != S_RUN);
  assign aborted     = aborted_q;
  assign run_cycles  = run_cycles_q;
  assign host_rdata  = mem_rdata;
  assign smp_data_in = mem_rdata;

endmodule
